// File: rtl/hapara_icap_pkg.sv
// Shared FSM encoding and ICAP constants for the ICAP reconfiguration arbiter.
// Purely declarative: no logic, no latency, no flow control.
package hapara_icap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [31:0] ICAP_SYNC_WORD = 32'hAA995566;
  localparam int          WORD_STRIDE    = 4;

endpackage

// File: rtl/hapara_icap_arbiter_rr.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping.
// Zero latency; holds no state, so the caller's FSM decides when to consume the grant.
module hapara_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin
    int  cand;
    logic found;
    cand  = 0;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/hapara_icap_arbiter.sv
// Round-robin ICAPE2 loader: streams len BRAM words into ICAP; first csib low 2 cycles after IDLE sample.
// No backpressure: requesters hold req until done; HAPARA_ICAP_BITSWAP_EN bit-reverses each byte.
module hapara_icap_arbiter
  import hapara_icap_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic                            bram_en,
  output logic [DATA_WIDTH-1:0]           bram_addr,
  input  logic [DATA_WIDTH-1:0]           bram_dout,
  output logic                            icap_csib,
  output logic                            icap_rdwrb,
  output logic [DATA_WIDTH-1:0]           icap_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       ptr, win, rr_idx;
  logic [NUM_REQ-1:0]     win_oh, rr_grant;
  logic [DATA_WIDTH-1:0]  base, win_addr, stream_dat;
  logic [LEN_WIDTH-1:0]   len, k, win_len;
  logic                   csib_q;

  hapara_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  always_comb begin
    win_addr = '0;
    win_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IDX_W'(i)) begin
        win_addr = req_addr[i*DATA_WIDTH +: DATA_WIDTH];
        win_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      win    <= '0;
      win_oh <= '0;
      base   <= '0;
      len    <= '0;
      k      <= '0;
      csib_q <= 1'b1;
    end else begin
      state  <= state_nxt;
      // ICAP consumes the word one cycle after its BRAM read was issued
      csib_q <= ~bram_en;
      case (state)
        ST_IDLE: if (|req) begin
          win    <= rr_idx;
          win_oh <= rr_grant;
        end
        ST_GRANT: begin
          base <= win_addr;
          len  <= win_len;
          k    <= LEN_WIDTH'(1);
        end
        ST_STREAM: k <= k + 1'b1;
        ST_DONE:   ptr <= (win == LAST_IDX) ? '0 : win + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    bram_en   = 1'b0;
    bram_addr = '0;
    done      = '0;
    case (state)
      ST_IDLE: if (|req) state_nxt = ST_GRANT;
      ST_GRANT: begin
        // word 0 is read straight from the winner's live address so csib can drop next cycle
        bram_en   = (win_len != '0);
        bram_addr = (win_len != '0) ? win_addr : '0;
        if (win_len == '0)                 state_nxt = ST_DONE;
        else if (win_len == LEN_WIDTH'(1)) state_nxt = ST_DRAIN;
        else                               state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        bram_en   = 1'b1;
        bram_addr = base + DATA_WIDTH'(k) * DATA_WIDTH'(WORD_STRIDE);
        if (k == len - 1'b1) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE: begin
        done      = win_oh;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef HAPARA_ICAP_BITSWAP_EN
  always_comb begin
    stream_dat = '0;
    for (int b = 0; b < DATA_WIDTH / 8; b++)
      for (int j = 0; j < 8; j++)
        stream_dat[b*8 + j] = bram_dout[b*8 + 7 - j];
  end
`else
  assign stream_dat = bram_dout;
`endif

  assign busy       = (state != ST_IDLE);
  assign icap_csib  = csib_q;
  assign icap_rdwrb = 1'b0;
  assign icap_i     = csib_q ? '0 : stream_dat;

endmodule

// File: doc/hapara_icap_arbiter.md
HAPARA_ICAP_ARBITER -- requirements
Module: hapara_icap_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning ICAP word and BRAM data width.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, meaning width of each request's word count.
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NUM_REQ  per-requester request level, held until matching done.
REQ-007 req_addr  input  NUM_REQ*DATA_WIDTH  per-requester bitstream byte base address.
REQ-008 req_len  input  NUM_REQ*LEN_WIDTH  per-requester word count.
REQ-009 done  output  NUM_REQ  one-cycle completion pulse per requester.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 bram_en, bram_addr  output  1, DATA_WIDTH  BRAM read port; read data valid one cycle after bram_en.
REQ-012 bram_dout  input  DATA_WIDTH  BRAM read data.
REQ-013 icap_csib, icap_rdwrb, icap_i  output  1, 1, DATA_WIDTH  ICAPE2 drive signals.

Function
REQ-014 SHALL implement states IDLE, GRANT, STREAM, DRAIN, DONE.
REQ-015 IDLE: if any req bit is high, SHALL select the winner by round-robin starting at pointer ptr, then go to GRANT.
REQ-016 GRANT: SHALL latch the winner's req_addr and req_len into internal registers; a latched length of 0 SHALL go directly to DONE with no BRAM or ICAP activity.
REQ-017 STREAM: SHALL assert bram_en with bram_addr = base + 4*k for k = 0..len-1, one word per cycle, then go to DRAIN.
REQ-018 Each cycle after a bram_en cycle SHALL drive icap_csib=0 and icap_i = bram_dout; icap_csib SHALL be low for exactly len consecutive cycles per transfer.
REQ-019 DRAIN: SHALL hold one cycle for the final word, then go to DONE.
REQ-020 DONE: SHALL pulse done[winner] for one cycle, set ptr = (winner+1) mod NUM_REQ, and return to IDLE.
REQ-021 Latency: first icap_csib low occurs two cycles after the IDLE cycle that samples req; done follows the last csib-low cycle by one cycle.
REQ-022 icap_rdwrb SHALL be constant 0 (write only); icap_csib SHALL be 1 and icap_i 0 outside the streaming window.
REQ-023 Address arithmetic SHALL wrap modulo 2^DATA_WIDTH; no error is flagged.
REQ-024 Deassertion of req or changes to req_addr/req_len mid-transfer SHALL be ignored; the transfer completes with the latched values.
REQ-025 A requester still holding req after its done SHALL be treated as a new request.
REQ-026 Simultaneous requests SHALL be served one at a time in round-robin order with no idle cycles beyond IDLE/GRANT/DONE.

Reset
REQ-027 rst low SHALL asynchronously force: state IDLE, ptr 0, done 0, busy 0, bram_en 0, bram_addr 0, icap_csib 1, icap_rdwrb 0, icap_i 0.
REQ-028 Reset mid-transfer SHALL abort the transfer with no done pulse; icap_csib SHALL go high in the same instant.

Configuration
REQ-029 With HAPARA_ICAP_BITSWAP_EN defined, icap_i SHALL equal bram_dout with the bit order reversed within each byte, matching ICAPE2 raw-bitstream ordering.
REQ-030 Without HAPARA_ICAP_BITSWAP_EN, icap_i SHALL equal bram_dout unmodified.

Structure
REQ-031 A shared package hapara_icap_pkg SHALL hold the state encoding constants, the ICAP sync word 32'hAA995566 used by benches, and the 4-byte word stride constant.
REQ-032 Winner selection SHALL be a sub-module hapara_rr_arbiter (inputs req and ptr; outputs one-hot grant and an index).

Verification
REQ-033 req=0001, addr0=0x100, len0=3: bram_addr 0x100/0x104/0x108; csib low for 3 cycles with matching data; done[0] pulses once.
REQ-034 req=1111 held, all len=2: grants in order 0,1,2,3; each done pulses once; csib high only during the IDLE/GRANT/DONE gaps.
REQ-035 req[2] with len=0: done[2] pulses once; bram_en and csib are never asserted.
REQ-036 rst low during k=5 of a len=10 transfer: csib goes high immediately; no done pulse; busy=0; the next request after rst restarts at k=0 from ptr 0.
REQ-037 bram_dout=0xAA995566: with HAPARA_ICAP_BITSWAP_EN, icap_i=0x5599AA66; without it, icap_i=0xAA995566.
REQ-038 addr=0xFFFFFFFC, len=2: bram_addr sequence is 0xFFFFFFFC then 0x00000000.
